// File: rtl/gb_intctl.sv
// Game Boy interrupt controller: IF/IE registers, fixed-priority vector to the CPU.
// Define GB_INTCTL_IRQ_EDGE_EN for rising-edge source detection (default: level).
module gb_intctl #(
  parameter logic [15:0] IF_ADDR = 16'hff0f,
  parameter logic [15:0] IE_ADDR = 16'hffff
) (
  input  logic        clock4,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  input  logic        load,
  input  logic        store,
  output logic [7:0]  rdata,
  output logic        hit,
  input  logic [4:0]  src,
  output logic        intreq,
  output logic [15:0] intaddress,
  input  logic        intack
);

  logic [4:0]  iflag_q, iflag_d;
  logic [7:0]  ie_q, ie_d;
  logic        intreq_q, intreq_d;
  logic [15:0] intaddress_q, intaddress_d;
  logic        ackd_q;
  logic [4:0]  set, clr, pend;
  logic [7:0]  off;
  logic [15:0] vec;

`ifdef GB_INTCTL_IRQ_EDGE_EN
  logic [4:0] src_d_q;
  always_ff @(posedge clock4) begin
    if (!resetn) src_d_q <= '0;
    else         src_d_q <= src;
  end
  assign set = src & ~src_d_q;
`else
  assign set = src;
`endif

  // Ack clears the bit belonging to the vector currently driven; non-vector addresses clear nothing.
  assign off = intaddress_q[7:0] - 8'h40;
  always_comb begin
    clr = '0;
    if (intack && intaddress_q[15:8] == 8'h00 && off <= 8'h20 && off[2:0] == 3'b000)
      clr[off[5:3]] = 1'b1;
  end

  assign pend = iflag_q & ie_q[4:0];

  // Scan downward so the lowest pending index wins.
  always_comb begin
    vec = 16'h0000;
    for (int i = 4; i >= 0; i--)
      if (pend[i]) vec = 16'h0040 + 16'(8 * i);
  end

  always_comb begin
    iflag_d      = (((store && address == IF_ADDR) ? wdata[4:0] : iflag_q) & ~clr) | set;
    ie_d         = (store && address == IE_ADDR) ? wdata : ie_q;
    intreq_d     = (pend != 5'd0) && !intack && !ackd_q;
    intaddress_d = (pend != 5'd0) ? vec : intaddress_q;
  end

  always_ff @(posedge clock4) begin
    if (!resetn) begin
      iflag_q      <= '0;
      ie_q         <= '0;
      intreq_q     <= 1'b0;
      intaddress_q <= '0;
      ackd_q       <= 1'b0;
    end else begin
      iflag_q      <= iflag_d;
      ie_q         <= ie_d;
      intreq_q     <= intreq_d;
      intaddress_q <= intaddress_d;
      ackd_q       <= intack;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (address == IF_ADDR)      rdata = {3'b111, iflag_q};
    else if (address == IE_ADDR) rdata = ie_q;
  end

  assign hit        = load && (address == IF_ADDR || address == IE_ADDR);
  assign intreq     = intreq_q;
  assign intaddress = intaddress_q;

endmodule

// File: tb/tb_gb_intctl.sv
// Scoreboard bench for gb_intctl: stimulus pushes expectations, negedge monitor pops and compares.
module tb_gb_intctl;

  localparam logic [15:0] IFA = 16'hff0f;
  localparam logic [15:0] IEA = 16'hffff;

  logic        clock4, resetn, load, store, intack, obs;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [4:0]  src;
  logic [7:0]  rdata;
  logic        hit, intreq;
  logic [15:0] intaddress;

  typedef struct {
    string       name;
    logic [7:0]  rd;
    logic        hit;
    logic        chk;
    logic        req;
    logic [15:0] va;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

`ifdef GB_INTCTL_IRQ_EDGE_EN
  localparam logic [7:0] HOLD_EXP = 8'he0;
`else
  localparam logic [7:0] HOLD_EXP = 8'he2;
`endif

  gb_intctl dut (
    .clock4(clock4), .resetn(resetn), .address(address), .wdata(wdata),
    .load(load), .store(store), .rdata(rdata), .hit(hit), .src(src),
    .intreq(intreq), .intaddress(intaddress), .intack(intack)
  );

  initial clock4 = 1'b0;
  always #5 clock4 = ~clock4;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clock4) begin
    if (obs) begin
      if (sb.size() == 0) begin
        n_run++; n_fail++;
        $display("FAIL scoreboard: output observed with no expectation queued");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp(e.name, "rdata", {8'h00, rdata}, {8'h00, e.rd});
        cmp(e.name, "hit", {15'd0, hit}, {15'd0, e.hit});
        if (e.chk) begin
          cmp(e.name, "intreq", {15'd0, intreq}, {15'd0, e.req});
          cmp(e.name, "intaddress", intaddress, e.va);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock4); #1;
    load = 0; store = 0; intack = 0; obs = 0; address = 16'h0000; wdata = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a; wdata = d; store = 1; cyc();
  endtask

  task automatic ack();
    intack = 1; cyc();
  endtask

  task automatic look(input string nm, input logic [15:0] a, input logic ld, input logic [7:0] erd,
                      input logic eh, input logic chk, input logic eq, input logic [15:0] ea);
    exp_t e;
    e.name = nm; e.rd = erd; e.hit = eh; e.chk = chk; e.req = eq; e.va = ea;
    sb.push_back(e);
    address = a; load = ld; obs = 1; cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn = 0; load = 0; store = 0; intack = 0; obs = 0;
    address = 16'h0000; wdata = 8'h00; src = 5'd0;
    cyc(); cyc();
    resetn = 1;
    look("rst_if", IFA, 1, 8'he0, 1, 1, 0, 16'h0000);
    look("rst_ie", IEA, 1, 8'h00, 1, 1, 0, 16'h0000);
    look("miss",   16'h1234, 1, 8'h00, 0, 1, 0, 16'h0000);

    // single source, 2-cycle latency, ack
    wr(IEA, 8'h1f);
    src = 5'b00100; cyc(); src = 5'd0;
    look("s2_if",  IFA, 1, 8'he4, 1, 1, 0, 16'h0000);
    look("s2_req", 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0050);
    ack();
    look("s2_ack", IFA, 1, 8'he0, 1, 1, 0, 16'h0050);

    // two sources, priority and post-ack gap
    src = 5'b11000; cyc(); src = 5'd0;
    look("s3_set",  16'h0000, 0, 8'h00, 0, 1, 0, 16'h0050);
    look("s3_v58",  IFA, 1, 8'hf8, 1, 1, 1, 16'h0058);
    ack();
    look("s3_ack1", IFA, 1, 8'hf0, 1, 1, 0, 16'h0058);
    look("s3_gap",  16'h0000, 0, 8'h00, 0, 1, 0, 16'h0060);
    look("s3_v60",  16'h0000, 0, 8'h00, 0, 1, 1, 16'h0060);
    ack();
    look("s3_ack2", IFA, 1, 8'he0, 1, 1, 0, 16'h0060);
    look("s3_idle", 16'h0000, 0, 8'h00, 0, 1, 0, 16'h0060);

    // masked source becomes visible after IE write
    wr(IEA, 8'h01);
    src = 5'b10000; cyc(); src = 5'd0;
    look("s4_if",  IFA, 1, 8'hf0, 1, 1, 0, 16'h0060);
    wr(IEA, 8'h10);
    look("s4_w",   IEA, 1, 8'h10, 1, 1, 0, 16'h0060);
    look("s4_v60", 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0060);
    ack(); cyc();

    // same-cycle precedence: set > ack clear > CPU write
    wr(IEA, 8'h01);
    src = 5'b00001; cyc(); src = 5'd0; cyc();
    look("s5_v40", 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0040);
    src = 5'b00001; intack = 1; address = IFA; wdata = 8'h00; store = 1; cyc(); src = 5'd0;
    look("s5_same", IFA, 1, 8'he1, 1, 1, 0, 16'h0040);
    wr(IFA, 8'h00); cyc(); cyc();

    // held-high source vs CPU clear
    wr(IEA, 8'h00);
    src = 5'b00010; cyc(); cyc();
    wr(IFA, 8'h00);
    look("s6_hold", IFA, 1, HOLD_EXP, 1, 1, 0, 16'h0040);
    src = 5'd0;
    wr(IFA, 8'h00);

    // reset mid-request, with ack and source in the reset cycle
    wr(IEA, 8'h1f);
    src = 5'b01000; cyc(); src = 5'd0; cyc();
    look("s7_req", 16'h0000, 0, 8'h00, 0, 1, 1, 16'h0058);
    resetn = 0; intack = 1; src = 5'b00001; cyc();
    resetn = 1; src = 5'd0;
    look("s7_rif", IFA, 1, 8'he0, 1, 1, 0, 16'h0000);
    look("s7_rie", IEA, 1, 8'h00, 1, 1, 0, 16'h0000);

    // ack with unloaded vector clears nothing
    wr(IFA, 8'h1f);
    ack();
    look("s8_nack", IFA, 1, 8'hff, 1, 1, 0, 16'h0000);

    cyc();
    cmp("drain", "queue", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_intctl.md
# gb_intctl

Game Boy interrupt controller that sits directly upstream of the CPU core. It collects the five peripheral interrupt sources into the memory-mapped IF register (0xFF0F) and masks them with the IE register (0xFFFF). It drives the CPU's `intreq`/`intaddress` pair with the highest-priority enabled vector, and clears the serviced flag when the CPU returns `intack`.

## Interface
Parameters:
- `IF_ADDR`, 16'hff0f, address of the interrupt flag register
- `IE_ADDR`, 16'hffff, address of the interrupt enable register

Ports:
- `clock4`  in  1  system clock; all state changes on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `address`  in  16  CPU bus address
- `wdata`  in  8  CPU write data (CPU `outdata`)
- `load`  in  1  CPU read strobe
- `store`  in  1  CPU write strobe
- `rdata`  out  8  read data for IF/IE
- `hit`  out  1  high when `load` targets IF_ADDR or IE_ADDR; bus mux selects `rdata`
- `src`  in  5  interrupt sources: [0] VBlank, [1] LCD STAT, [2] Timer, [3] Serial, [4] Joypad
- `intreq`  out  1  registered interrupt request to CPU
- `intaddress`  out  16  registered vector for the current request
- `intack`  in  1  CPU acknowledge, one cycle, for the vector currently on `intaddress`

## Operation
- State:
  - `iflag[4:0]`
  - `ie[7:0]`
  - `src_d[4:0]` (edge-detect history; present only with the macro)
  - `intreq`, `intaddress`
  - `ack_d` (suppress flag)
- Set mask `set[4:0]`: `src & ~src_d` with IRQ_EDGE_EN; `src` without it.
- Ack mask `clr[4:0]`: when `intack`=1, one-hot bit `(intaddress[7:0]-8'h40)>>3`; otherwise 0.
- IF next state: `iflag <= ((store && address==IF_ADDR) ? wdata[4:0] : iflag) & ~clr | set`.
- Precedence for the same bit in the same cycle: source set > ack clear > CPU write.
- IE: `store && address==IE_ADDR` → `ie <= wdata`. All 8 bits are stored; only `ie[4:0]` masks.
- Pending vector `p = iflag & ie[4:0]`. Priority: bit 0 highest, bit 4 lowest.
- Vectors are 16'h0040 + 8·idx: 0x40, 0x48, 0x50, 0x58, 0x60.
- Every cycle:
  - `intreq <= (p != 0) && !intack && !ack_d`
  - `intaddress <= vector(highest p)`; held unchanged when `p == 0`
  - `ack_d <= intack`
- Reads (combinational from the registers):
  - IF_ADDR → {3'b111, iflag}
  - IE_ADDR → ie
  - any other address → 8'h00 with `hit`=0
- `hit = load && (address==IF_ADDR || address==IE_ADDR)`.
- The CPU master-enable (IME) lives in the CPU, not here. `intreq` is asserted regardless of IME.

## Timing
- Reset (`resetn`=0 at a rising edge) sets:
  - `iflag`=0, `ie`=0, `src_d`=0
  - `intreq`=0, `intaddress`=16'h0000, `ack_d`=0
- Reset has priority over every input in that cycle. A request in progress is dropped, and an `intack` in the reset cycle is ignored.
- Source event sampled at edge N → IF bit set after edge N → `intreq`/`intaddress` valid after edge N+1 (2-cycle latency).
- IE or IF write at edge N → reflected on `intreq` after edge N+1.
- `intack` at edge N clears the acked IF bit at edge N. `intreq` is forced low after edges N and N+1, then re-evaluates from the updated IF; the next vector appears after edge N+2.
- A higher-priority source arriving while `intreq`=1 changes `intaddress` one cycle after its IF bit is set. `intack` always clears the bit matching the vector driven in that cycle.
- `intack` while `intreq`=0 with `intaddress`=0x0000 (never loaded) clears nothing. Any `intaddress` outside 0x40–0x60 maps to an empty `clr`.
- Reads have zero latency (same cycle as `load`). A write followed by a read in the next cycle returns the new value.

## Configuration
- `GB_INTCTL_IRQ_EDGE_EN` defined:
  - sources are rising-edge detected via `src_d`
  - a held-high source sets IF once; a CPU clear of IF stays cleared until the source deasserts and reasserts
- Undefined:
  - `src_d` is removed and `set = src` (level)
  - a held-high source re-sets IF every cycle, so a CPU clear or `intack` is overridden while the source stays high

## Test plan
- Reset, then read 0xFF0F and 0xFFFF → `rdata` 8'hE0 and 8'h00, `hit`=1. `intreq`=0, `intaddress`=16'h0000.
- Write IE=8'h1F, pulse `src[2]` 1 cycle at edge N → IF reads 8'hE4. `intreq`=1 with `intaddress`=16'h0050 after edge N+1.
- IE=8'h1F, `src`=5'b11000 pulsed together → vector 0x0058. `intack` → IF=8'hF0, `intreq` low 2 cycles, then vector 0x0060. `intack` → IF=8'hE0, `intreq` stays 0.
- IE=8'h01 and `src[4]` pulsed → IF=8'hF0, `intreq` stays 0. Write IE=8'h10 → `intreq`=1 with vector 0x0060 two edges after the write.
- Same cycle: `src[0]` rises, `intack` for 0x0040, and `store` IF=8'h00 → IF bit 0 ends set (reads 8'hE1).
- With edge detect on: hold `src[1]` high, write IF=0 → IF stays 8'hE0. Without the macro → IF reads 8'hE2 the next cycle. Assert `resetn`=0 mid-request → all outputs return to their reset values at that edge.
